// File: rtl/bisc_input_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : bisc_input_fetcher
// Description : Upstream feeder for the MVM controller. Prefetches elements
//               from a valid/ready source into a 2-entry FIFO and answers the
//               controller's level request with a one-cycle input_ready pulse
//               and a registered element. Counts delivered elements per run,
//               flags the last element of the sweep and counts starvation
//               cycles.
// Ports       : clock, reset (async, active-low)
//               start                      - arms a new run (pulse)
//               src_valid/src_data/src_ready - source stream handshake
//               input_req                  - level request from controller
//               input_ready/data_out       - delivery pulse and element
//               elem_count                 - elements delivered this run
//               last_elem                  - final element of the sweep
//               starve_cycles              - saturating starvation counter
// Revision    : 1.0 - initial release
// ============================================================================
module bisc_input_fetcher #(
    parameter int DATA_WIDTH   = 8,
    parameter int INPUT_WIDTH  = 4,
    parameter int INPUT_HEIGHT = 4,
    parameter int COUNT_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    input  logic                  input_req,
    output logic                  input_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [COUNT_W-1:0]    elem_count,
    output logic                  last_elem,
    output logic [15:0]           starve_cycles
);

    localparam int               c_TOTAL = INPUT_WIDTH * INPUT_HEIGHT;
    localparam logic [COUNT_W-1:0] c_LAST_IDX = COUNT_W'(c_TOTAL - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_mem0;
    logic [DATA_WIDTH-1:0] r_mem1;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_fill;
    logic                  r_input_ready;
    logic                  r_last_elem;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic [COUNT_W-1:0]    r_elem_count;
    logic [15:0]           r_starve;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_src_ready;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_starve;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_empty     = (r_fill == 2'd0);
    assign w_full      = (r_fill == 2'd2);
    assign w_src_ready = (r_state != c_ST_IDLE) && !w_full;
    assign w_push      = src_valid && w_src_ready;
    // Pop uses the pre-push occupancy, so an empty FIFO never bypasses.
    assign w_pop       = (r_state == c_ST_ARMED) && input_req && !w_empty;
    assign w_starve    = (r_state == c_ST_ARMED) && input_req && w_empty;
    assign w_head      = r_rd_ptr ? r_mem1 : r_mem0;

    // FIFO storage and pointers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem0   <= '0;
            r_mem1   <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_fill   <= 2'd0;
        end else begin
            if (w_push) begin
                if (r_wr_ptr) r_mem1 <= src_data;
                else          r_mem0 <= src_data;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 2'd1;
                2'b01:   r_fill <= r_fill - 2'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Run control, delivery and counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_input_ready <= 1'b0;
            r_last_elem   <= 1'b0;
            r_data_out    <= '0;
            r_elem_count  <= '0;
            r_starve      <= 16'd0;
        end else begin
            r_input_ready <= w_pop;
            r_last_elem   <= w_pop && (r_elem_count == c_LAST_IDX);
            if (w_pop) begin
                r_data_out   <= w_head;
                r_elem_count <= r_elem_count + COUNT_W'(1);
            end
            if (w_starve && (r_starve != 16'hFFFF)) begin
                r_starve <= r_starve + 16'd1;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_elem_count <= '0;
                        r_starve     <= 16'd0;
                        r_state      <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    if (w_pop) begin
                        r_state <= (r_elem_count == c_LAST_IDX) ? c_ST_IDLE
                                                                : c_ST_HOLD;
                    end
                end
                // One dead cycle: the controller's request is still high
                // while it samples input_ready.
                c_ST_HOLD: r_state <= c_ST_ARMED;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign src_ready     = w_src_ready;
    assign input_ready   = r_input_ready;
    assign last_elem     = r_last_elem;
    assign data_out      = r_data_out;
    assign elem_count    = r_elem_count;
    assign starve_cycles = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_bisc_input_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_bisc_input_fetcher
// Description : Self-checking bench for bisc_input_fetcher. Source elements
//               are queued as expected results when offered; each delivery
//               pops and compares the head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bisc_input_fetcher;

    localparam int DATA_WIDTH   = 8;
    localparam int INPUT_WIDTH  = 4;
    localparam int INPUT_HEIGHT = 4;
    localparam int COUNT_W      = 4;
    localparam int TOTAL        = INPUT_WIDTH * INPUT_HEIGHT;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic                  src_valid = 1'b0;
    logic [DATA_WIDTH-1:0] src_data = '0;
    logic                  src_ready;
    logic                  input_req = 1'b0;
    logic                  input_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic [COUNT_W-1:0]    elem_count;
    logic                  last_elem;
    logic [15:0]           starve_cycles;

    int n_vec = 0;
    int n_err = 0;
    int m_idx = 0;
    int n_last = 0;
    logic [DATA_WIDTH-1:0] exp_q[$];

    bisc_input_fetcher #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INPUT_WIDTH (INPUT_WIDTH),
        .INPUT_HEIGHT(INPUT_HEIGHT),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .input_req    (input_req),
        .input_ready  (input_ready),
        .data_out     (data_out),
        .elem_count   (elem_count),
        .last_elem    (last_elem),
        .starve_cycles(starve_cycles)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Delivery monitor: every input_ready pulse pops one expected element.
    always @(negedge clock) begin
        if (reset) begin
            if (input_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("unexpected_delivery", 32'd1, 32'd0);
                end else begin
                    check_value("data_out", 32'(data_out), 32'(exp_q.pop_front()));
                end
                check_value("last_elem", 32'(last_elem), 32'(m_idx == TOTAL - 1));
                if (last_elem) n_last++;
                m_idx++;
            end else if (last_elem) begin
                check_value("last_without_ready", 32'd1, 32'd0);
            end
        end
    end

    // Offer one element and hold it until accepted.
    task automatic send(input logic [DATA_WIDTH-1:0] v);
        logic acc;
        int   n;
        n = 0;
        @(negedge clock);
        src_valid = 1'b1;
        src_data  = v;
        exp_q.push_back(v);
        forever begin
            acc = src_ready;
            @(negedge clock);
            if (acc) break;
            n++;
            if (n > 60) begin
                check_value("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        src_valid = 1'b0;
    endtask

    // Controller model: raise request, drop it once input_ready is seen.
    task automatic request();
        bit seen;
        seen = 1'b0;
        @(negedge clock);
        input_req = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (input_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_value("req_timeout", 32'd0, 32'd1);
        input_req = 1'b0;
    endtask

    task automatic do_start(input bit fresh);
        @(negedge clock);
        start = 1'b1;
        if (fresh) m_idx = 0;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check_value("rst_src_ready", 32'(src_ready), 32'd0);
        check_value("rst_input_ready", 32'(input_ready), 32'd0);
        check_value("rst_data_out", 32'(data_out), 32'd0);
        check_value("rst_elem_count", 32'(elem_count), 32'd0);
        check_value("rst_starve", 32'(starve_cycles), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_value("idle_src_ready", 32'(src_ready), 32'd0);

        // Basic run: 0x01..0x10
        do_start(1'b1);
        fork
            begin
                for (int i = 1; i <= TOTAL; i++) send(DATA_WIDTH'(i));
            end
            begin
                for (int i = 0; i < TOTAL; i++) begin
                    request();
                    if (i == TOTAL - 2)
                        check_value("cnt_15", 32'(elem_count), 32'(TOTAL - 1));
                end
            end
        join
        @(negedge clock);
        check_value("basic_count", 32'(elem_count), 32'(COUNT_W'(TOTAL)));
        check_value("basic_last_pulses", 32'(n_last), 32'd1);
        check_value("basic_idle", 32'(src_ready), 32'd0);
        check_value("basic_q_empty", 32'(exp_q.size()), 32'd0);

        // Starvation: five empty-request cycles, then 0xA5
        do_start(1'b1);
        input_req = 1'b1;
        repeat (5) @(negedge clock);
        check_value("starve_5", 32'(starve_cycles), 32'd5);
        src_valid = 1'b1;
        src_data  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clock);
        src_valid = 1'b0;
        check_value("starve_no_bypass", 32'(input_ready), 32'd0);
        @(negedge clock);
        check_value("starve_ready", 32'(input_ready), 32'd1);
        input_req = 1'b0;

        // Backpressure: 0x11, 0x22 fill the FIFO, 0x33 is held
        @(negedge clock);
        src_valid = 1'b1;
        src_data  = 8'h11;
        exp_q.push_back(8'h11);
        check_value("bp_ready0", 32'(src_ready), 32'd1);
        @(negedge clock);
        src_data = 8'h22;
        exp_q.push_back(8'h22);
        @(negedge clock);
        src_data = 8'h33;
        exp_q.push_back(8'h33);
        check_value("bp_full", 32'(src_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_value("bp_hold", 32'(src_ready), 32'd0);
        end

        // Latency/HOLD: request high for two cycles gives one pulse
        input_req = 1'b1;
        @(negedge clock);
        check_value("lat_first", 32'(input_ready), 32'd1);
        @(negedge clock);
        check_value("lat_hold", 32'(input_ready), 32'd0);
        input_req = 1'b0;
        src_valid = 1'b0;
        @(negedge clock);
        check_value("lat_no_second", 32'(input_ready), 32'd0);
        request();
        request();
        @(negedge clock);
        check_value("count_4", 32'(elem_count), 32'd4);

        // start ignored mid-run
        for (int i = 4; i <= 6; i++) begin
            fork
                send(DATA_WIDTH'(i * 8'h11));
                request();
            join
        end
        send(8'h77);
        do_start(1'b0);
        check_value("start_ign_count", 32'(elem_count), 32'd7);
        check_value("start_ign_armed", 32'(src_ready), 32'd1);
        request();
        @(negedge clock);
        check_value("start_ign_count8", 32'(elem_count), 32'd8);

        // Asynchronous reset between edges
        send(8'h88);
        input_req = 1'b1;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        input_req = 1'b0;
        check_value("arst_count", 32'(elem_count), 32'd0);
        check_value("arst_data", 32'(data_out), 32'd0);
        check_value("arst_starve", 32'(starve_cycles), 32'd0);
        check_value("arst_src_ready", 32'(src_ready), 32'd0);
        check_value("arst_ready", 32'(input_ready), 32'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        do_start(1'b1);
        fork
            send(8'h99);
            request();
        join
        @(negedge clock);
        check_value("arst_fresh_count", 32'(elem_count), 32'd1);
        check_value("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
